// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide sequencer.
//   op_t    : operation codes presented on the op input (110/111 reserved)
//   state_t : sequencer FSM states
//   abs32   : magnitude of a 32-bit operand, honouring signedness
package muldiv_pkg;

  localparam int ITERS_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // -2^31 maps to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: iterative datapath shared by multiply and divide.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch operand magnitudes, clear counter
//   step       : perform one iteration this cycle
//   is_div     : 1 = restoring-divide step, 0 = shift-add multiply step
//   mag_a/mag_b: unsigned operand magnitudes (sampled on load)
//   acc        : {HI-half, LO-half}; product, or {remainder, quotient}
//   last       : the current step is the final one
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] mag_a,
  input  logic [31:0] mag_b,
  output logic [63:0] acc,
  output logic        last
);

  localparam int CNT_W = $clog2(ITERS);

  logic [CNT_W-1:0] count;
  logic [31:0]      b_q;
  logic [32:0]      mul_sum;
  logic [64:0]      div_sh;
  logic [33:0]      div_diff;
  logic [63:0]      acc_next;

  always_comb begin
    // Multiply: add b to the upper half when the LSB is set, then shift right
    // with the carry entering at the top.
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
    // Divide: shift {rem, quot} left, try subtracting b from the 33-bit partial
    // remainder; keep it and set the quotient bit when no borrow occurs.
    div_sh   = {acc, 1'b0};
    div_diff = {1'b0, div_sh[64:32]} - {2'b00, b_q};
    if (is_div) begin
      if (!div_diff[33]) acc_next = {div_diff[31:0], div_sh[31:1], 1'b1};
      else               acc_next = {div_sh[63:32], div_sh[31:1], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
    end
  end

  assign last = (count == CNT_W'(ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      b_q   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= {32'd0, mag_a};
      b_q   <= mag_b;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: MIPS-style HI/LO multiply/divide unit.
//   op_valid/op/a/b : operation request; accepted when op_valid && op_ready
//   op_ready        : high in IDLE only
//   rd_req/rd_sel   : HI (1) / LO (0) read; rd_data is combinational
//   stall           : read requested while a mul/div is in flight
//   busy            : mul/div in flight
//   done            : one-cycle pulse after HI/LO are written by mul/div
//   fsm_state       : current FSM state, for observation
// Handshake: an op transfers on a rising edge where op_valid && op_ready; a
// read is valid in any cycle where stall is 0, and the requester holds rd_req
// while stall is 1.
module mult_div_sequencer
  import muldiv_pkg::*;
#(
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        op_ready,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output state_t      fsm_state
);

  state_t      state, state_next;
  logic        load, step, wr_fix, wr_mthi, wr_mtlo, sgn_op;
  logic [31:0] hi, lo;
  logic        neg_a, neg_b, b_zero;
  logic [31:0] a_raw;
  logic [63:0] acc;
  logic        last;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix, hi_new, lo_new;

  muldiv_iter_dp #(.ITERS(ITERS)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (state == S_DIV),
    .mag_a  (abs32(a, sgn_op)),
    .mag_b  (abs32(b, sgn_op)),
    .acc    (acc),
    .last   (last)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    wr_fix     = 1'b0;
    wr_mthi    = 1'b0;
    wr_mtlo    = 1'b0;
    sgn_op     = (op == OP_MULT) || (op == OP_DIV);
    case (state)
      S_IDLE: if (op_valid) begin
        case (op)
          OP_MULT, OP_MULTU: begin state_next = S_MUL; load = 1'b1; end
          OP_DIV,  OP_DIVU:  begin state_next = S_DIV; load = 1'b1; end
          OP_MTHI:           wr_mthi = 1'b1;
          OP_MTLO:           wr_mtlo = 1'b1;
          default:           ;
        endcase
      end
      S_MUL, S_DIV: begin
        step = 1'b1;
        if (last) state_next = S_FIX;
      end
      S_FIX: begin
        wr_fix     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sign correction applied in FIX. Divide by zero bypasses it entirely so the
  // result is the raw dividend in HI and all-ones in LO for both signednesses.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
    q_fix    = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
    r_fix    = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
    if (state == S_MUL) begin
      hi_new = prod_fix[63:32];
      lo_new = prod_fix[31:0];
    end else if (b_zero) begin
      hi_new = a_raw;
      lo_new = 32'hFFFF_FFFF;
    end else begin
      hi_new = r_fix;
      lo_new = q_fix;
    end
  end

  // The FIX state has to remember whether it came from MUL or DIV; a small
  // flag keeps that without adding FSM states.
  logic was_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      b_zero  <= 1'b0;
      a_raw   <= '0;
      was_mul <= 1'b0;
    end else begin
      state <= state_next;
      done  <= wr_fix;
      if (load) begin
        neg_a   <= sgn_op && a[31];
        neg_b   <= sgn_op && b[31];
        b_zero  <= (b == 32'd0);
        a_raw   <= a;
        was_mul <= (op == OP_MULT) || (op == OP_MULTU);
      end
      if (wr_mthi) hi <= a;
      if (wr_mtlo) lo <= a;
      if (wr_fix) begin
        if (was_mul) begin
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
        end else begin
          hi <= hi_new;
          lo <= lo_new;
        end
      end
    end
  end

  assign op_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign stall     = rd_req && busy;
  assign rd_data   = rd_sel ? hi : lo;
  assign fsm_state = state;

endmodule
